// File: rtl/cash_debounce.sv
// cash_debounce: synchronise and debounce six cash buttons, one clean pulse per press.
// Macro CASH_SERIALIZE_EN: serialise simultaneous presses into spaced one-hot pulses.
module cash_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 20,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] key_raw,
  output logic [5:0] cash_Input,
  output logic [5:0] key_stable,
  output logic       busy
);

  localparam int unsigned N_KEYS = 6;

  logic [N_KEYS-1:0] s1_q, s2_q;
  logic [N_KEYS-1:0] stable_q, stable_d, stable_prev_q;
  logic [N_KEYS-1:0] rise_c;
  logic [N_KEYS-1:0] cash_q, cash_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
    end
  end

  // Any bounce back to the stable level restarts the count
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise_c     = stable_q & ~stable_prev_q;
  assign key_stable = stable_q;
  assign cash_Input = cash_q;

`ifdef CASH_SERIALIZE_EN
  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_e;

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] sel_c, clr_c;
  logic              busy_q, busy_d;

  // Lowest pending index has priority
  assign sel_c = pending_q & (~pending_q + N_KEYS'(1));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cash_d  = '0;
    clr_c   = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          cash_d  = sel_c;
          clr_c   = sel_c;
          state_d = EMIT;
        end
      end
      EMIT: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES <= 1) ? IDLE : GAP;
      end
      GAP: begin
        if (int'(gap_q) >= GAP_CYCLES - 2) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new press on the bit being emitted this cycle must survive the clear
    pending_d = (pending_q & ~clr_c) | rise_c;
    busy_d    = (state_d != IDLE) | (|pending_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      pending_q <= '0;
      cash_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      cash_q    <= cash_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  assign cash_d = rise_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cash_q <= '0;
    end else begin
      cash_q <= cash_d;
    end
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_cash_debounce.sv
// tb_cash_debounce: directed scenarios plus random button activity, checked against
// an edge-history model of debounce/serialise behaviour (follows CASH_SERIALIZE_EN).
module tb_cash_debounce;

  localparam int D = 20;
  localparam int G = 2;
`ifdef CASH_SERIALIZE_EN
  localparam int LAT = D + 4;
`else
  localparam int LAT = D + 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] key_raw = '0;
  logic [5:0] cash_Input;
  logic [5:0] key_stable;
  logic       busy;

  int tests = 0;
  int fails = 0;

  cash_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20),
    .GAP_CYCLES     (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .cash_Input(cash_Input),
    .key_stable(key_stable),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, expv, $time);
    end
  endtask

  // Model: raw sample history; a bit flips once its last D synchronised samples all disagree
  logic [5:0] m_d1, m_d2;
  logic [5:0] m_win [D];
  logic [5:0] m_st, m_st_old, m_pend, m_cash, m_rise, m_sel, m_diff;
  logic       m_busy;
  int         m_cyc, m_next_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_st = '0; m_st_old = '0;
      m_pend = '0; m_cash = '0; m_busy = 1'b0;
      m_cyc = 0; m_next_ok = 0;
      for (int k = 0; k < D; k++) m_win[k] = '0;
    end else begin
      m_cyc++;
      m_rise = m_st & ~m_st_old;
`ifdef CASH_SERIALIZE_EN
      m_sel = '0;
      if (m_pend != 0 && m_cyc >= m_next_ok) begin
        for (int b = 5; b >= 0; b--) if (m_pend[b]) m_sel = 6'(1 << b);
        m_next_ok = m_cyc + G + 1;
      end
      m_pend = (m_pend & ~m_sel) | m_rise;
      m_cash = m_sel;
      m_busy = (m_cyc < m_next_ok - 1) || (m_pend != 0);
`else
      m_cash = m_rise;
      m_busy = 1'b0;
`endif
      for (int k = D - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_d2;
      m_diff = '1;
      for (int k = 0; k < D; k++) m_diff = m_diff & (m_win[k] ^ m_st);
      m_st_old = m_st;
      m_st     = m_st ^ m_diff;
      m_d2     = m_d1;
      m_d1     = key_raw;
    end
  end

  // Every cycle: DUT against the model
  always @(posedge clk) begin
    #1;
    check("model_cash", cash_Input, m_cash);
    check("model_stable", key_stable, m_st);
    check("model_busy", {5'b0, busy}, {5'b0, m_busy});
  end

  // Literal pulse schedule for edges 1..n after the current negedge
  task automatic expect_run(input string nm, input int n,
                            input int e1, input logic [5:0] p1,
                            input int e2, input logic [5:0] p2,
                            input int e3, input logic [5:0] p3,
                            input int st_edge, input logic [5:0] st_mask,
                            input int busy_edge);
    for (int k = 1; k <= n; k++) begin
      logic [5:0] want;
      @(posedge clk);
      #1;
      want = (k == e1) ? p1 : (k == e2) ? p2 : (k == e3) ? p3 : 6'b0;
      check({nm, "_cash"}, cash_Input, want);
      if (st_edge > 0 && k == st_edge - 1) check({nm, "_stable_pre"}, key_stable & st_mask, 6'b0);
      if (st_edge > 0 && k == st_edge) check({nm, "_stable_post"}, key_stable & st_mask, st_mask);
      if (busy_edge > 0) begin
`ifdef CASH_SERIALIZE_EN
        if (k == busy_edge - 1) check({nm, "_busy_hi"}, {5'b0, busy}, 6'd1);
        if (k == busy_edge) check({nm, "_busy_lo"}, {5'b0, busy}, 6'd0);
`else
        check({nm, "_busy_zero"}, {5'b0, busy}, 6'd0);
`endif
      end
    end
  endtask

  initial begin
    int hold;
    // Reset held with all keys pressed
    key_raw = '1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("rst_cash", cash_Input, 6'b0);
      check("rst_stable", key_stable, 6'b0);
      check("rst_busy", {5'b0, busy}, 6'b0);
    end
    @(negedge clk);
    key_raw = '0;
    rst     = 1'b0;
    repeat (10) @(negedge clk);

    // Single press on denomination 2
    key_raw = 6'b000100;
    expect_run("single", 40, LAT, 6'b000100, 0, 6'b0, 0, 6'b0, D + 2, 6'b000100, 0);
    @(negedge clk);
    key_raw = '0;
    repeat (40) @(negedge clk);

    // Bounce on bit 0 shorter than the debounce window
    for (int t = 0; t < 60; t++) begin
      if (t % 5 == 0) key_raw[0] = ~key_raw[0];
      @(posedge clk);
      #1;
      check("bounce_cash", cash_Input, 6'b0);
      check("bounce_stable", key_stable, 6'b0);
      @(negedge clk);
    end
    key_raw = '0;
    repeat (40) @(negedge clk);

    // Simultaneous press on bits 0, 4, 5
`ifdef CASH_SERIALIZE_EN
    key_raw = 6'b110001;
    expect_run("simul", 40, LAT, 6'b000001, LAT + 3, 6'b010000, LAT + 6, 6'b100000, 0, 6'b0, LAT + 8);
`else
    key_raw = 6'b110001;
    expect_run("simul", 40, LAT, 6'b110001, 0, 6'b0, 0, 6'b0, 0, 6'b0, 1);
`endif
    @(negedge clk);
    key_raw = '0;
    repeat (50) @(negedge clk);

    // Reset while bits 4 and 5 are pending, keys held throughout
    key_raw = 6'b110000;
    repeat (D + 3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_cash", cash_Input, 6'b0);
    check("rstmid_busy", {5'b0, busy}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
`ifdef CASH_SERIALIZE_EN
    expect_run("rstmid", 35, LAT, 6'b010000, LAT + 3, 6'b100000, 0, 6'b0, D + 2, 6'b110000, 0);
`else
    expect_run("rstmid", 35, LAT, 6'b110000, 0, 6'b0, 0, 6'b0, D + 2, 6'b110000, 0);
`endif
    @(negedge clk);
    key_raw = '0;
    repeat (40) @(negedge clk);

    // Random presses, bounces and occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 3) == 0) key_raw = 6'($urandom);
      else key_raw[$urandom_range(0, 5)] = ~key_raw[$urandom_range(0, 5)];
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      hold = $urandom_range(1, 45);
      repeat (hold) @(negedge clk);
    end
    key_raw = '0;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cash_debounce.md
# cash_debounce

Front-end conditioner for the six cash-denomination buttons of the vending machine. It synchronises and debounces the raw board inputs, turns each press into exactly one single-cycle pulse, and serialises simultaneous presses. Its `cash_Input[5:0]` output drives the `cash_Input` port of `cashInput` directly, so the credit accumulator sees one clean one-hot pulse per coin or note.

## Interface
- `DEBOUNCE_CYCLES`, default 20: consecutive stable cycles required to accept a level change. The board build sets 1_000_000; benches use 20.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `GAP_CYCLES`, default 2: idle cycles inserted between serialised pulses.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `key_raw`  in  6: raw, asynchronous, bouncing buttons. Bit i is denomination i.
- `cash_Input`  out  6: registered press pulse. Zero or one-hot with serialisation, any pattern without it. High for exactly 1 cycle per press.
- `key_stable`  out  6: debounced level of each button.
- `busy`  out  1: high while any press is pending or the serialiser is not IDLE.

## Operation
- **Synchroniser:** each bit passes through a 2-FF synchroniser (`s1`, `s2`), reset to 0.
- **Debounce counter (per bit):**
  - If `s2 != key_stable`: the counter increments.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing: `key_stable <= s2` and the counter returns to 0.
  - If `s2 == key_stable`: the counter returns to 0, so any bounce restarts the count.
- **Edge detect:** a 0→1 transition of `key_stable[i]` sets `pending[i]`. A 1→0 transition is ignored.
- **Serialiser FSM, states IDLE, EMIT, GAP:**
  - IDLE: if `pending != 0`, select the lowest set index i. Drive `cash_Input <= (1<<i)`, clear `pending[i]`, and go to EMIT. Otherwise `cash_Input <= 0`.
  - EMIT (1 cycle): `cash_Input <= 0`. Go to GAP with the gap counter set to 0. If GAP_CYCLES = 0, go straight to IDLE.
  - GAP: wait GAP_CYCLES-1 further cycles, then go to IDLE.
  - Net effect: successive pulses are GAP_CYCLES+1 cycles apart, start to start.
- **Set/clear collision:** if the same bit is set and cleared in the same cycle, set wins and no press is lost.
- **Merging:** a new press on a bit that is already pending merges into one pulse. Legal configurations require DEBOUNCE_CYCLES ≥ 6·(GAP_CYCLES+1), which makes merging impossible for real presses.
- **busy** = (`state != IDLE`) | (`|pending`).

## Timing
- **Reset values:** `cash_Input` = 0, `key_stable` = 0, `busy` = 0. `s1`, `s2`, all counters and `pending` clear to 0, and the FSM returns to IDLE.
- **Edge numbering:** edge 1 is the first clock edge that samples `key_raw[i]` high, with the input held thereafter.
  - `s2` high after edge 2.
  - `key_stable` high after edge D+2 (D = DEBOUNCE_CYCLES).
  - `pending` set at edge D+3.
  - `cash_Input` pulse asserted at edge D+4 and low at edge D+5, when no other press is ahead of it.
- **Release:** `key_stable` falls D+2 edges after release. No pulse is generated.
- **Reset mid-operation:**
  - Pending presses are discarded, and any pulse in flight is cut.
  - A key still held when `rst` deasserts is re-debounced and produces a new pulse. This is required behaviour.

## Configuration
- Macro `CASH_SERIALIZE_EN`.
- **Defined:** serialiser FSM as above; `cash_Input` is always zero or one-hot.
- **Undefined:**
  - No FSM and no pending register.
  - `cash_Input <= rising-edge vector of key_stable`, registered, so the pulse is asserted at edge D+3, one cycle earlier than with serialisation.
  - Simultaneous presses appear together in one cycle.
  - `busy` is tied to 0.

## Test plan
All scenarios use D=20 and GAP_CYCLES=2 unless noted.
1. **Reset:** hold `rst` for 5 cycles with `key_raw` = 6'b111111. Every output reads 0 during reset.
2. **Single press:** `key_raw[2]` held for 40 cycles. Exactly one pulse, `cash_Input` = 6'b000100, at edge 24 only. `key_stable[2]` rises after edge 22.
3. **Bounce:** `key_raw[0]` toggles every 5 cycles for 60 cycles, then stays 0. `key_stable` stays 0 and no pulse occurs.
4. **Simultaneous press:** `key_raw[0]`, `[4]`, `[5]` rise together and are held, with `CASH_SERIALIZE_EN` defined. Pulses are 000001 at edge 24, 010000 at edge 27, and 100000 at edge 30. `busy` falls after the last GAP.
5. **Reset mid-operation:** with bits 4 and 5 pending, pulse `rst` for 1 cycle with keys held. No stale pulse appears. After release, the keys re-debounce and pulses 010000 and 100000 appear at edges 24 and 27 after `rst` deasserts.
6. **Macro undefined:** same stimulus as scenario 4. A single pulse, `cash_Input` = 6'b110001, at edge 23, and `busy` stays 0.
